// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX between NUM_REQ requesters; optional busy-rise watchdog via UART_ARB_TIMEOUT_EN.
// Latency: req_ready/uart_data_en one cycle after req_valid sampled in IDLE; req_done one cycle after tx_busy falls.
// Backpressure: holds off grants while uart_tx_busy is high; requesters hold valid/data until their req_ready pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 25,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                req_data,
    output logic [NUM_REQ-1:0]                           req_ready,
    output logic [NUM_REQ-1:0]                           req_done,
    output logic [DATA_WIDTH-1:0]                        uart_data_input,
    output logic                                         uart_data_en,
    input  logic                                         uart_tx_busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                         arb_busy,
    output logic [NUM_REQ-1:0]                           timeout_err
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and BUSY_TIMEOUT >= 1");
    end

    state_t                  r_state, w_state_nxt;
    logic [GW-1:0]           r_last_grant, w_last_nxt;
    logic [GW-1:0]           r_grant_id, w_gid_nxt;
    logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
    logic                    r_en, w_en_nxt;
    logic                    r_arb_busy;
    logic [NUM_REQ-1:0]      r_ready, w_ready_nxt;
    logic [NUM_REQ-1:0]      r_done, w_done_nxt;
    logic [GW-1:0]           w_winner;
    logic [DATA_WIDTH-1:0]   w_win_data;
    int                      w_best_d;
    int                      w_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NUM_REQ-1:0]      r_tout, w_tout_nxt;
`endif

    // Winner = valid requester with the smallest rotating distance past last_grant.
    always_comb begin
        w_best_d   = NUM_REQ;
        w_d        = 0;
        w_winner   = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_d = i - int'(r_last_grant) - 1;
            if (w_d < 0) w_d = w_d + NUM_REQ;
            if (req_valid[i] && (w_d < w_best_d)) begin
                w_best_d   = w_d;
                w_winner   = GW'(i);
                w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_gid_nxt   = r_grant_id;
        w_data_nxt  = r_data;
        w_en_nxt    = r_en;
        w_ready_nxt = '0;
        w_done_nxt  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        w_tout_nxt  = '0;
        w_cnt_inc   = r_cnt + 1'b1;
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if ((|req_valid) && !uart_tx_busy) begin
                    w_gid_nxt             = w_winner;
                    w_data_nxt            = w_win_data;
                    w_en_nxt              = 1'b1;
                    w_ready_nxt[w_winner] = 1'b1;
                    w_state_nxt           = START;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_nxt             = '0;
`endif
                end
            end
            START: begin
                if (uart_tx_busy) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (w_cnt_inc == CW'(BUSY_TIMEOUT)) begin
                    w_en_nxt               = 1'b0;
                    w_tout_nxt[r_grant_id] = 1'b1;
                    w_last_nxt             = r_grant_id;
                    w_state_nxt            = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`endif
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    w_done_nxt[r_grant_id] = 1'b1;
                    w_last_nxt             = r_grant_id;
                    w_state_nxt            = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_data       <= '0;
            r_en         <= 1'b0;
            r_arb_busy   <= 1'b0;
            r_ready      <= '0;
            r_done       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_tout       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_grant_id   <= w_gid_nxt;
            r_data       <= w_data_nxt;
            r_en         <= w_en_nxt;
            r_arb_busy   <= (w_state_nxt != IDLE);
            r_ready      <= w_ready_nxt;
            r_done       <= w_done_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt        <= w_cnt_nxt;
            r_tout       <= w_tout_nxt;
`endif
        end
    end

    assign req_ready       = r_ready;
    assign req_done        = r_done;
    assign uart_data_input = r_data;
    assign uart_data_en    = r_en;
    assign grant_id        = r_grant_id;
    assign arb_busy        = r_arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err     = r_tout;
`else
    assign timeout_err     = '0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART TX busy model and loopback capture.
module tb_uart_tx_arbiter;
    localparam int N     = 3;
    localparam int DW    = 25;
    localparam int TMO   = 8;
    localparam int FRAME = 6;
    localparam int K_RDY = 0, K_DONE = 1, K_TOUT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready, req_done, timeout_err;
    logic [DW-1:0]   uart_data_input;
    logic            uart_data_en, uart_tx_busy, arb_busy;
    logic [1:0]      grant_id;

    typedef struct { int kind; int id; logic [DW-1:0] dat; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // 0 = modelled UART, 1 = busy forced high, 2 = busy forced low
    int            busy_mode = 0;
    logic          m_busy = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] m_rx = '0;

    always #5 clk = ~clk;
    assign uart_tx_busy = m_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .uart_data_input(uart_data_input),
        .uart_data_en(uart_data_en), .uart_tx_busy(uart_tx_busy), .grant_id(grant_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (busy_mode == 1) begin
            m_busy <= 1'b1;
        end else if (busy_mode == 2) begin
            m_busy <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_busy <= 1'b0;
        end else if (m_busy) begin
            m_busy <= 1'b0;
        end else if (uart_data_en) begin
            m_busy <= 1'b1;
            m_cnt  <= FRAME;
            m_rx   <= uart_data_input;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int id, input logic [DW-1:0] d);
        exp_t e;
        e.kind = k; e.id = id; e.dat = d;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int k);
        exp_t e;
        logic [N-1:0] v;
        logic [N-1:0] oh;
        v = (k == K_RDY) ? req_ready : (k == K_DONE) ? req_done : timeout_err;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", {29'd0, v}, 32'd0);
            return;
        end
        e  = sb.pop_front();
        oh = N'(1) << e.id;
        chk("ev_kind", k, e.kind);
        chk("ev_onehot", {29'd0, v}, {29'd0, oh});
        chk("ev_grant_id", {30'd0, grant_id}, e.id);
        if (k == K_RDY) begin
            chk("rdy_data_input", {7'd0, uart_data_input}, {7'd0, e.dat});
            chk("rdy_data_en", {31'd0, uart_data_en}, 32'd1);
            chk("rdy_arb_busy", {31'd0, arb_busy}, 32'd1);
        end else begin
            if (k == K_DONE) chk("done_loopback_rx", {7'd0, m_rx}, {7'd0, e.dat});
            chk("end_data_en", {31'd0, uart_data_en}, 32'd0);
            chk("end_arb_busy", {31'd0, arb_busy}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (|req_ready)   check_ev(K_RDY);
        if (|req_done)    check_ev(K_DONE);
        if (|timeout_err) check_ev(K_TOUT);
    end

    function automatic bit cond(input int w);
        case (w)
            0:       return |req_ready;
            1:       return |req_done;
            2:       return |timeout_err;
            default: return arb_busy && !uart_data_en;
        endcase
    endfunction

    task automatic wait_for(input int w, input string nm, output int n);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (cond(w)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: event not seen within 200 cycles", nm);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, {29'd0, req_ready}, 32'd0);
        chk({p, "_done"}, {29'd0, req_done}, 32'd0);
        chk({p, "_data_input"}, {7'd0, uart_data_input}, 32'd0);
        chk({p, "_data_en"}, {31'd0, uart_data_en}, 32'd0);
        chk({p, "_grant_id"}, {30'd0, grant_id}, 32'd0);
        chk({p, "_arb_busy"}, {31'd0, arb_busy}, 32'd0);
        chk({p, "_timeout_err"}, {29'd0, timeout_err}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_zero("reset");

        // single request, data changed after capture
        expect_ev(K_RDY, 0, 25'h15234A5);
        expect_ev(K_DONE, 0, 25'h15234A5);
        rst = 1'b0;
        req_data[0 +: DW] = 25'h15234A5;
        req_valid = 3'b001;
        wait_for(0, "single_ready", n);
        chk("single_latency", n, 1);
        req_valid = '0;
        req_data[0 +: DW] = 25'h0BADBAD;
        wait_for(1, "single_done", n);

        // round robin from reset, all held valid
        do_reset();
        expect_ev(K_RDY, 0, 25'd1); expect_ev(K_DONE, 0, 25'd1);
        expect_ev(K_RDY, 1, 25'd2); expect_ev(K_DONE, 1, 25'd2);
        expect_ev(K_RDY, 2, 25'd3); expect_ev(K_DONE, 2, 25'd3);
        expect_ev(K_RDY, 0, 25'd1); expect_ev(K_DONE, 0, 25'd1);
        expect_ev(K_RDY, 1, 25'd2); expect_ev(K_DONE, 1, 25'd2);
        req_data  = {25'd3, 25'd2, 25'd1};
        req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, "rr_ready", n);
            if (k == 0) chk("rr_first_latency", n, 1);
        end
        req_valid = '0;
        wait_for(1, "rr_last_done", n);

        // late arrival of requester 2 during WAIT_DONE
        do_reset();
        expect_ev(K_RDY, 0, 25'h0AAAAAA); expect_ev(K_DONE, 0, 25'h0AAAAAA);
        expect_ev(K_RDY, 2, 25'h1555555); expect_ev(K_DONE, 2, 25'h1555555);
        req_data[0 +: DW]    = 25'h0AAAAAA;
        req_data[2*DW +: DW] = 25'h1555555;
        req_valid = 3'b001;
        wait_for(0, "late_ready0", n);
        req_valid = '0;
        wait_for(4, "late_wait_done", n);
        req_valid = 3'b100;
        wait_for(1, "late_done0", n);
        chk("late_no_ready_at_done", {29'd0, req_ready}, 32'd0);
        wait_for(0, "late_ready2", n);
        chk("late_gap", n, 1);
        req_valid = '0;
        wait_for(1, "late_done2", n);

        // tx_busy high while idle blocks the grant
        busy_mode = 1;
        @(negedge clk);
        expect_ev(K_RDY, 1, 25'h0C0FFEE); expect_ev(K_DONE, 1, 25'h0C0FFEE);
        req_data[DW +: DW] = 25'h0C0FFEE;
        req_valid = 3'b010;
        repeat (4) @(negedge clk);
        chk("busy_no_grant", {29'd0, req_ready}, 32'd0);
        chk("busy_idle_arb_busy", {31'd0, arb_busy}, 32'd0);
        busy_mode = 0;
        wait_for(0, "busy_ready", n);
        chk("busy_release_latency", n, 2);
        req_valid = '0;
        wait_for(1, "busy_done", n);

        // reset in WAIT_DONE abandons the frame, priority back to 0
        expect_ev(K_RDY, 2, 25'h1555555);
        req_valid = 3'b100;
        wait_for(0, "rstmid_ready", n);
        req_valid = '0;
        wait_for(4, "rstmid_wait_done", n);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rstmid");
        rst = 1'b0;
        expect_ev(K_RDY, 0, 25'h0AAAAAA); expect_ev(K_DONE, 0, 25'h0AAAAAA);
        req_valid = 3'b111;
        wait_for(0, "rstmid_prio_ready", n);
        chk("rstmid_prio_latency", n, 1);
        req_valid = '0;
        wait_for(1, "rstmid_prio_done", n);

`ifdef UART_ARB_TIMEOUT_EN
        // tx_busy never rises: watchdog fires, next requester proceeds
        busy_mode = 2;
        expect_ev(K_RDY, 1, 25'h0C0FFEE); expect_ev(K_TOUT, 1, 25'h0C0FFEE);
        expect_ev(K_RDY, 2, 25'h1555555); expect_ev(K_DONE, 2, 25'h1555555);
        req_valid = 3'b010;
        wait_for(0, "tmo_ready", n);
        req_valid = '0;
        wait_for(2, "tmo_err", n);
        chk("tmo_cycles", n, TMO);
        busy_mode = 0;
        req_valid = 3'b101;
        wait_for(0, "tmo_next_ready", n);
        chk("tmo_next_latency", n, 1);
        req_valid = '0;
        wait_for(1, "tmo_next_done", n);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ on-chip requesters using round-robin arbitration.
- Captures a winner's frame and drives the transmitter's data_input/data_en.
- Tracks tx_busy through the whole frame, then pulses a per-requester done.
- Sits between bus-side debug/report sources and the single uart instance's TX path.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- DATA_WIDTH, 25: frame width; must match uart TX_DATA_WIDTH.
- BUSY_TIMEOUT, 64: cycles to wait for tx_busy to rise after data_en (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- req_valid  in  NUM_REQ  requester i has a frame pending.
- req_data  in  NUM_REQ*DATA_WIDTH  frame of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-cycle pulse: frame of requester i captured.
- req_done  out  NUM_REQ  one-cycle pulse: frame of requester i fully shifted out.
- uart_data_input  out  DATA_WIDTH  to uart data_input.
- uart_data_en  out  1  to uart data_en.
- uart_tx_busy  in  1  from uart tx_busy.
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of current or last winner.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  NUM_REQ  one-cycle pulse on timeout; constant 0 without the macro.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Timeout counter 0.
- Reset mid-frame:
  - Abandons the frame and drops uart_data_en in the next cycle.
  - No req_done is issued.
  - The uart itself is reset by its own rstn.
- IDLE:
  - Grants only when at least one req_valid is high and uart_tx_busy=0.
  - Winner g is the first valid index searching last_grant+1, +2, ..., with wrap modulo NUM_REQ.
  - At that edge: uart_data_input<=req_data[g], grant_id<=g, req_ready[g]<=1 for one cycle, uart_data_en<=1, state<=START.
  - Grant latency: 1 cycle from req_valid sampled high to req_ready/uart_data_en high.
- START:
  - Holds uart_data_en=1 and uart_data_input stable.
  - When uart_tx_busy=1 is sampled: uart_data_en<=0, state<=WAIT_DONE.
- WAIT_DONE:
  - When uart_tx_busy=0 is sampled: req_done[g]<=1 for one cycle, last_grant<=g, state<=IDLE.
  - The earliest next grant is the cycle after returning to IDLE; back-to-back frames have a minimum 1 idle cycle.
- Requester rules:
  - Hold req_valid and req_data stable until req_ready pulses.
  - After req_ready, the requester may change data or drop valid.
  - req_data changes after capture have no effect.
  - Dropping req_valid before the grant withdraws the request silently.
- Simultaneous events:
  - Several valid requesters: exactly one grant per frame, in rotating order.
  - A single requester that is continuously valid gets every slot.
  - req_valid for the currently granted index during START/WAIT_DONE is ignored until IDLE.
- At most one bit of req_ready, req_done or timeout_err is high in any cycle.
- arb_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter starts at 0 on entry to START and increments each START cycle.
  - If it reaches BUSY_TIMEOUT with uart_tx_busy still 0: uart_data_en<=0, timeout_err[g] pulses 1 cycle, last_grant<=g, state<=IDLE.
  - No req_done is issued for that frame.
- Without the macro:
  - START waits indefinitely.
  - timeout_err is tied to 0 and no counter is synthesized.

Test Plan:
- Single request: rst released, req_valid=3'b001, req_data[0]=25'h15234A5 -> req_ready[0] pulse the next cycle; uart_data_input=25'h15234A5 with data_en high until tx_busy rises; req_done[0] pulses once tx_busy falls; a looped-back receiver uart outputs 25'h15234A5.
- Round-robin: all three valid from reset with frames 25'h0000001/25'h0000002/25'h0000003, held valid -> grant order 0,1,2,0,1,...; req_done order matches; never two grants in one frame.
- Late arrival: requester 2 valid while frame 0 is in WAIT_DONE, requester 1 idle -> next grant is 2, and it follows ≥1 idle cycle after req_done[0].
- Busy at idle: uart_tx_busy forced 1 while in IDLE with req_valid=3'b010 -> no grant until tx_busy=0, then req_ready[1] on the next cycle.
- Reset mid-frame: rst pulsed in WAIT_DONE -> the next cycle shows all outputs 0 and state IDLE; after release, requester 0 has priority again (last_grant=NUM_REQ-1).
- UART_ARB_TIMEOUT_EN defined, BUSY_TIMEOUT=8, uart_tx_busy held 0 -> timeout_err[g] pulses 8 cycles after data_en rises; data_en drops; no req_done; the next valid requester is granted afterwards.
